// File: rtl/mvm_seq_sat.sv
// Row-sequential saturating matrix-vector multiply: one output row per clock, result held until accepted.
// Optional per-row saturation flags are enabled by defining MVM_SAT_FLAG_EN.
module mvm_seq_sat #(
    parameter int N      = 8,
    parameter int S      = 8,
    parameter int R      = 4,
    parameter int SIGNED = 0
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [R*S*N-1:0] w,
    input  logic [S*N-1:0]   u,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [R*N-1:0]   v
`ifdef MVM_SAT_FLAG_EN
    ,
    output logic [R-1:0]     sat_flag
`endif
);

    localparam int RW = (R > 1) ? $clog2(R) : 1;
    // Wide enough that neither a full product nor a clamped-operand sum can wrap.
    localparam int PW = 2 * N + 2;

    localparam logic signed [PW-1:0] ONE  = PW'(1);
    localparam logic signed [PW-1:0] MAXV = (SIGNED != 0) ? (ONE <<< (N - 1)) - ONE : (ONE <<< N) - ONE;
    localparam logic signed [PW-1:0] MINV = (SIGNED != 0) ? -(ONE <<< (N - 1)) : PW'(0);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [RW-1:0]      row_q, row_d;
    logic [R*S*N-1:0]   w_q, w_d;
    logic [S*N-1:0]     u_q, u_d;
    logic [R*N-1:0]     v_q, v_d;
    logic [N-1:0]       row_v;
    logic signed [PW-1:0] prod, m, sum, acc, acc_n;
`ifdef MVM_SAT_FLAG_EN
    logic [R-1:0]       flag_q, flag_d;
    logic               row_sat;
`endif

    function automatic logic signed [PW-1:0] ext(input logic [N-1:0] e);
        if (SIGNED != 0) begin
            return {{(PW - N){e[N-1]}}, e};
        end
        return {{(PW - N){1'b0}}, e};
    endfunction

    function automatic logic signed [PW-1:0] clamp(input logic signed [PW-1:0] x);
        if (x > MAXV) begin
            return MAXV;
        end
        if (x < MINV) begin
            return MINV;
        end
        return x;
    endfunction

    // Accumulation is folded strictly in column order; reordering changes saturated results.
    always_comb begin
        prod  = '0;
        m     = '0;
        sum   = '0;
        acc   = '0;
        acc_n = '0;
`ifdef MVM_SAT_FLAG_EN
        row_sat = 1'b0;
`endif
        for (int unsigned i = 0; i < S; i++) begin
            prod  = ext(w_q[(int'(row_q) * S + i) * N +: N]) * ext(u_q[i * N +: N]);
            m     = clamp(prod);
            sum   = (i == 0) ? m : acc + m;
            acc_n = clamp(sum);
`ifdef MVM_SAT_FLAG_EN
            row_sat = row_sat | (m != prod) | (acc_n != sum);
`endif
            acc = acc_n;
        end
        row_v = acc[N-1:0];
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            w_q     <= '0;
            u_q     <= '0;
            v_q     <= '0;
`ifdef MVM_SAT_FLAG_EN
            flag_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            w_q     <= w_d;
            u_q     <= u_d;
            v_q     <= v_d;
`ifdef MVM_SAT_FLAG_EN
            flag_q  <= flag_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        w_d     = w_q;
        u_d     = u_q;
        v_d     = v_q;
`ifdef MVM_SAT_FLAG_EN
        flag_d  = flag_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    w_d     = w;
                    u_d     = u;
                    row_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                v_d[int'(row_q) * N +: N] = row_v;
`ifdef MVM_SAT_FLAG_EN
                flag_d[row_q] = row_sat;
`endif
                if (row_q == RW'(R - 1)) begin
                    row_d   = '0;
                    state_d = DONE;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = reset_n && (state_q == IDLE);
        out_valid = (state_q == DONE);
        v         = v_q;
`ifdef MVM_SAT_FLAG_EN
        sat_flag  = flag_q;
`endif
    end

endmodule

// File: tb/tb_mvm_seq_sat.sv
// Scoreboard bench for mvm_seq_sat: an unsigned R=2 instance and a signed R=4 instance share clock and reset.
// Build with MVM_SAT_FLAG_EN defined to also check the saturation flags.
module tb_mvm_seq_sat;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0]  a_w;
    logic [31:0]  a_u;
    logic [15:0]  a_v;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [127:0] b_w;
    logic [31:0]  b_u;
    logic [31:0]  b_v;
`ifdef MVM_SAT_FLAG_EN
    logic [1:0]   a_flag;
    logic [3:0]   b_flag;
`endif

    mvm_seq_sat #(.N(8), .S(4), .R(2), .SIGNED(0)) u_dut_a (
        .CLOCK_50(clk), .reset_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .w(a_w), .u(a_u), .out_valid(a_out_valid), .out_ready(a_out_ready), .v(a_v)
`ifdef MVM_SAT_FLAG_EN
        , .sat_flag(a_flag)
`endif
    );

    mvm_seq_sat #(.N(8), .S(4), .R(4), .SIGNED(1)) u_dut_b (
        .CLOCK_50(clk), .reset_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .w(b_w), .u(b_u), .out_valid(b_out_valid), .out_ready(b_out_ready), .v(b_v)
`ifdef MVM_SAT_FLAG_EN
        , .sat_flag(b_flag)
`endif
    );

    typedef struct {
        logic [31:0] v;
        logic [3:0]  f;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int clampi(input int x, input bit sgn, inout bit f);
        int hi = sgn ? 127 : 255;
        int lo = sgn ? -128 : 0;
        if (x > hi) begin f = 1'b1; return hi; end
        if (x < lo) begin f = 1'b1; return lo; end
        return x;
    endfunction

    function automatic exp_t model(input bit sgn, input int rows, input logic [127:0] wv, input logic [31:0] uv);
        exp_t e;
        e.v = '0;
        e.f = '0;
        for (int r = 0; r < rows; r++) begin
            int acc = 0;
            bit f = 1'b0;
            for (int i = 0; i < 4; i++) begin
                logic [7:0] ew, eu;
                int a, b, mm;
                ew = wv[(r * 4 + i) * 8 +: 8];
                eu = uv[i * 8 +: 8];
                a  = sgn ? int'($signed(ew)) : int'({24'b0, ew});
                b  = sgn ? int'($signed(eu)) : int'({24'b0, eu});
                mm = clampi(a * b, sgn, f);
                acc = (i == 0) ? mm : clampi(acc + mm, sgn, f);
            end
            e.v[r * 8 +: 8] = acc[7:0];
            e.f[r] = f;
        end
        return e;
    endfunction

    task automatic send_a(input logic [63:0] wv, input logic [31:0] uv);
        @(negedge clk);
        a_w = wv; a_u = uv; a_in_valid = 1'b1;
        for (int k = 0; k < 20 && !a_in_ready; k++) @(negedge clk);
        check("a_accept_ready", a_in_ready, 1);
        @(posedge clk);
        qa.push_back(model(1'b0, 2, {64'b0, wv}, uv));
        #1 a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [127:0] wv, input logic [31:0] uv);
        @(negedge clk);
        b_w = wv; b_u = uv; b_in_valid = 1'b1;
        for (int k = 0; k < 20 && !b_in_ready; k++) @(negedge clk);
        check("b_accept_ready", b_in_ready, 1);
        @(posedge clk);
        qb.push_back(model(1'b1, 4, wv, uv));
        #1 b_in_valid = 1'b0;
    endtask

    task automatic recv_a(input int hold, output logic [15:0] got);
        exp_t e;
        for (int k = 0; k < 20 && !a_out_valid; k++) @(negedge clk);
        check("a_out_valid", a_out_valid, 1);
        got = a_v;
        check("a_q_nonempty", qa.size() != 0, 1);
        if (qa.size() != 0) begin
            e = qa.pop_front();
            check("a_v", a_v, e.v[15:0]);
`ifdef MVM_SAT_FLAG_EN
            check("a_flag", a_flag, e.f[1:0]);
`endif
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check("a_hold_v", a_v, e.v[15:0]);
                check("a_hold_valid", a_out_valid, 1);
            end
        end
        a_out_ready = 1'b1;
        @(posedge clk);
        #1 a_out_ready = 1'b0;
        check("a_idle_ready", a_in_ready, 1);
        check("a_idle_valid", a_out_valid, 0);
    endtask

    task automatic recv_b(input int hold, output logic [31:0] got);
        exp_t e;
        for (int k = 0; k < 20 && !b_out_valid; k++) @(negedge clk);
        check("b_out_valid", b_out_valid, 1);
        got = b_v;
        check("b_q_nonempty", qb.size() != 0, 1);
        if (qb.size() != 0) begin
            e = qb.pop_front();
            check("b_v", b_v, e.v);
`ifdef MVM_SAT_FLAG_EN
            check("b_flag", b_flag, e.f);
`endif
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check("b_hold_v", b_v, e.v);
            end
        end
        b_out_ready = 1'b1;
        @(posedge clk);
        #1 b_out_ready = 1'b0;
        check("b_idle_ready", b_in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ga;
        logic [31:0] gb;
        exp_t e1;
        rst_n = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_w = '0; a_u = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_w = '0; b_u = '0;
        #2 rst_n = 1'b0;
        #2;
        check("rst_a_ready", a_in_ready, 0);
        check("rst_a_valid", a_out_valid, 0);
        check("rst_a_v", a_v, 0);
        check("rst_b_ready", b_in_ready, 0);
        check("rst_b_v", b_v, 0);
`ifdef MVM_SAT_FLAG_EN
        check("rst_b_flag", b_flag, 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_rel_ready", a_in_ready, 1);

        // Unsigned: row0 = 4*(3*2) = 24, row1 = 4*128 saturates to 255
        send_a(64'h40404040_03030303, 32'h02020202);
        recv_a(0, ga);
        check("t1_v", ga, 16'hFF18);
`ifdef MVM_SAT_FLAG_EN
        check("t1_flag", a_flag, 2'b10);
`endif

        // Signed: -128 * -1 clamps to 127; row1 exercises order-dependent saturation
        send_b(128'h80, 32'h000000FF);
        recv_b(0, gb);
        check("t2_v0", gb, 32'h0000007F);
        send_b({64'h0, 32'h9C9C6464, 32'h0}, 32'h01010101);
        recv_b(0, gb);
        check("t2_v1", gb, 32'h0000B700);

        // Latency and no-accept in COMPUTE/DONE with in_valid held high
        @(negedge clk);
        a_w = 64'h01020304_05060708; a_u = 32'h11223344; a_in_valid = 1'b1;
        check("t3_ready_pre", a_in_ready, 1);
        @(posedge clk);
        qa.push_back(model(1'b0, 2, {64'b0, a_w}, a_u));
        #1;
        check("t3_ready_e0", a_in_ready, 0);
        check("t3_valid_e0", a_out_valid, 0);
        @(posedge clk); #1;
        check("t3_valid_e1", a_out_valid, 0);
        check("t3_ready_e1", a_in_ready, 0);
        @(posedge clk); #1;
        check("t3_valid_e2", a_out_valid, 1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("t3_done_ready", a_in_ready, 0);
            check("t3_done_valid", a_out_valid, 1);
        end
        a_in_valid = 1'b0;
        recv_a(5, ga);

        // Async reset in the middle of a signed computation (row 1 of 4)
        send_b(128'h11111111_22222222_33333333_44444444, 32'h05050505);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_valid", b_out_valid, 0);
        check("t5_v", b_v, 0);
        check("t5_ready", b_in_ready, 0);
        check("t5_a_v", a_v, 0);
        void'(qb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("t5_rel_ready", b_in_ready, 1);
        send_b(128'h7F7F7F7F_80808080_0A0BF5F6_01020304, 32'h7F80FF02);
        recv_b(2, gb);

        // Back-to-back: in_valid and out_ready held high; operand change after accept is ignored
        @(negedge clk);
        a_w = 64'hFFFF0000_10203040; a_u = 32'h01020304;
        a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk);
        e1 = model(1'b0, 2, {64'b0, a_w}, a_u);
        #1 a_w = 64'h0F0F0F0F_80808080; a_u = 32'h01010101;
        @(posedge clk);
        @(posedge clk); #1;
        check("t6_valid1", a_out_valid, 1);
        check("t6_v1", a_v, e1.v[15:0]);
        @(posedge clk); #1;
        check("t6_exit_ready", a_in_ready, 1);
        check("t6_exit_valid", a_out_valid, 0);
        @(posedge clk);
        qa.push_back(model(1'b0, 2, {64'b0, a_w}, a_u));
        #1;
        check("t6_second_accept", a_in_ready, 0);
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        recv_a(0, ga);

        for (int t = 0; t < 6; t++) begin
            send_a({$urandom(), $urandom()}, $urandom());
            recv_a(t % 2, ga);
            send_b({$urandom(), $urandom(), $urandom(), $urandom()}, $urandom());
            recv_b(t % 3, gb);
        end

        check("qa_empty", qa.size(), 0);
        check("qb_empty", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
